fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. Holds the program counter, drives the synchronous instruction ROM, and presents each fetched instruction with its PC and a valid flag to the IF/ID pipeline register. Supports hazard stalls without losing the in-flight instruction and taken-branch/jump redirects from EX, inserting bubbles for killed wrong-path fetches.

---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, sync ROM drive, stall hold, redirect kill
// Optional halt-opcode stop is built when FETCH_HALT_EN is defined.
module fetch_stage #(
    parameter int              PC_W        = 16,
    parameter int              INSTR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    rom_addr_o,
    input  logic [INSTR_W-1:0] rom_data_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o,
    output logic               halted_o
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     fpc_q, fpc_d;
    logic                fvalid_q, fvalid_d;
    logic                stalled_q, stalled_d;
    logic [INSTR_W-1:0]  hold_q, hold_d;

    logic advance;
    logic hold_stall;
    logic halt_hit;

    assign rom_addr_o = pc_q;
    // The ROM moves on to pc_q while stalled, so the in-flight word is kept in hold_q.
    assign instr_o    = stalled_q ? hold_q : rom_data_i;
    assign pc_o       = fpc_q;
    assign valid_o    = fvalid_q & ~redirect_i;

    assign advance    = ~redirect_i & ~(stall_i & fvalid_q) & (state_q != HALTED);
    assign hold_stall = stall_i & fvalid_q & ~redirect_i;

`ifdef FETCH_HALT_EN
    // The halt instruction leaves this cycle; the fetch behind it is dropped.
    assign halt_hit = (state_q == RUN) & advance & valid_o
                    & (instr_o[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign halted_o = (state_q == HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted_o = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_q;
        fpc_d     = fpc_q;
        fvalid_d  = fvalid_q;
        stalled_d = stalled_q;
        hold_d    = hold_q;
        state_d   = state_q;
        if (redirect_i) begin
            pc_d      = redirect_pc_i;
            fvalid_d  = 1'b0;
            stalled_d = 1'b0;
            state_d   = FILL;
        end else if (halt_hit) begin
            fvalid_d  = 1'b0;
            stalled_d = 1'b0;
            state_d   = HALTED;
        end else if (advance) begin
            fpc_d     = pc_q;
            pc_d      = pc_q + 1'b1;
            fvalid_d  = 1'b1;
            stalled_d = 1'b0;
            if (state_q == FILL) begin
                state_d = RUN;
            end
        end else if (hold_stall) begin
            if (!stalled_q) begin
                hold_d = rom_data_i;
            end
            stalled_d = 1'b1;
        end else if (state_q == HALTED) begin
            fvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            pc_q      <= RESET_PC;
            fpc_q     <= '0;
            fvalid_q  <= 1'b0;
            stalled_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fpc_q     <= fpc_d;
            fvalid_q  <= fvalid_d;
            stalled_q <= stalled_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (halt path under FETCH_HALT_EN)
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .halted_o      (halted)
    );

    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return (a == 16'h0080) ? 16'hF000 : 16'h1000 + a;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // An instruction is consumed by IF/ID when it is valid and not held by a stall.
    always @(negedge clk) begin
        if (rst_n && valid && !stall) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_pc", {16'h0, pc}, 32'hDEAD);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check_eq("sb_pc", {16'h0, pc}, {16'h0, e});
                check_eq("sb_instr", {16'h0, instr}, {16'h0, rom_fn(e)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (3) step();
        at_neg();
        check_eq("rst_valid", {31'h0, valid}, 32'h0);
        check_eq("rst_pc", {16'h0, pc}, 32'h0);
        check_eq("rst_addr", {16'h0, rom_addr}, 32'h0);
        check_eq("rst_halted", {31'h0, halted}, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
        at_neg();
        check_eq("c0_valid", {31'h0, valid}, 32'h0);
        check_eq("c0_addr", {16'h0, rom_addr}, 32'h0);
        step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check_eq("stall_pc", {16'h0, pc}, 32'h2);
            check_eq("stall_instr", {16'h0, instr}, 32'h1002);
            check_eq("stall_valid", {31'h0, valid}, 32'h1);
            step();
        end
        stall = 1'b0;
        at_neg();
        check_eq("unstall_pc", {16'h0, pc}, 32'h2);
        check_eq("unstall_instr", {16'h0, instr}, 32'h1002);
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 16'h0040;
        exp_q.push_back(16'h0040);
        at_neg();
        check_eq("redir_kill_valid", {31'h0, valid}, 32'h0);
        step();
        redirect = 1'b0;
        at_neg();
        check_eq("redir_bubble_valid", {31'h0, valid}, 32'h0);
        step();
        at_neg();
        check_eq("redir_target_pc", {16'h0, pc}, 32'h40);
        check_eq("redir_target_valid", {31'h0, valid}, 32'h1);
        step();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
        exp_q.push_back(16'h0010); exp_q.push_back(16'h0011); exp_q.push_back(16'h0012);
        at_neg();
        check_eq("sr_kill_valid", {31'h0, valid}, 32'h0);
        step();
        redirect = 1'b0;
        at_neg();
        check_eq("sr_bubble_valid", {31'h0, valid}, 32'h0);
        step();
        stall = 1'b0;
        at_neg();
        check_eq("sr_target_pc", {16'h0, pc}, 32'h10);
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        step();
        redirect = 1'b0;
        step(); step(); step();
        at_neg();
        check_eq("wrap_pc", {16'h0, pc}, 32'h0);
        check_eq("wrap_valid", {31'h0, valid}, 32'h1);
        step(); step();
        redirect = 1'b1; redirect_pc = 16'h007E;
        exp_q.push_back(16'h007E); exp_q.push_back(16'h007F); exp_q.push_back(16'h0080);
`ifndef FETCH_HALT_EN
        exp_q.push_back(16'h0081); exp_q.push_back(16'h0082);
`endif
        step();
        redirect = 1'b0;
        step(); step(); step();
        at_neg();
        check_eq("halt_instr_valid", {31'h0, valid}, 32'h1);
        check_eq("halt_instr", {16'h0, instr}, 32'hF000);
        step();
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check_eq("halted_valid", {31'h0, valid}, 32'h0);
            check_eq("halted_flag", {31'h0, halted}, 32'h1);
            check_eq("halted_addr", {16'h0, rom_addr}, 32'h81);
            step();
        end
        redirect = 1'b1; redirect_pc = 16'h0000;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        step();
        redirect = 1'b0;
        at_neg();
        check_eq("unhalt_flag", {31'h0, halted}, 32'h0);
        step(); step(); step();
`else
        at_neg();
        check_eq("nohalt_flag", {31'h0, halted}, 32'h0);
        check_eq("nohalt_next_pc", {16'h0, pc}, 32'h81);
        step(); step();
`endif
        stall = 1'b1;
        at_neg();
        check_eq("pre_rst_valid", {31'h0, valid}, 32'h1);
        step();
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'h0, valid}, 32'h0);
        check_eq("async_rst_pc", {16'h0, pc}, 32'h0);
        check_eq("async_rst_addr", {16'h0, rom_addr}, 32'h0);
        stall = 1'b0;
        step(); step();
        rst_n = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        step();
        at_neg();
        check_eq("post_rst_pc", {16'h0, pc}, 32'h0);
        check_eq("post_rst_instr", {16'h0, instr}, 32'h1000);
        step(); step();
        check_eq("sb_drain", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
